// File: rtl/wb_regfile.sv
// wb_regfile: architectural integer register file written by the writeback stage
// and read by decode, plus a retired-instruction counter.
// Register 0 is hardwired to zero. Reads are combinational.
// Optional feature macro: RF_BYPASS_EN adds a write-through path on both read ports.
// Without RF_BYPASS_EN, reads return the array contents from before the edge.
module wb_regfile #(
  parameter int                 DATA_W   = 64,
  parameter int                 ADDR_W   = 5,
  parameter int                 SP_IDX   = 2,
  parameter logic [DATA_W-1:0]  SP_RESET = '0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              W_valid_i,
  input  logic [ADDR_W-1:0] W_dstE_i,
  input  logic [DATA_W-1:0] W_valE_i,
  input  logic [ADDR_W-1:0] W_dstM_i,
  input  logic [DATA_W-1:0] W_valM_i,
  input  logic [ADDR_W-1:0] d_srcA_i,
  input  logic [ADDR_W-1:0] d_srcB_i,
  output logic [DATA_W-1:0] d_rvalA_o,
  output logic [DATA_W-1:0] d_rvalB_o,
  output logic [63:0]       instret_o
);

  localparam int NREGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [63:0]       instret_q;

  logic commit;
  logic we_e;
  logic we_m;

  // A commit is a real W-stage instruction in a non-reset cycle. The load result
  // wins when both destinations name the same register, so port E is suppressed.
  assign commit = W_valid_i && !rst_i;
  assign we_e   = commit && (W_dstE_i != '0) && (W_dstE_i != W_dstM_i);
  assign we_m   = commit && (W_dstM_i != '0);

  // Value seen by one read port: zero for index 0, optionally the in-flight
  // writeback value, otherwise the stored register.
  function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] src);
    logic [DATA_W-1:0] val;
    val = regs_q[src];
`ifdef RF_BYPASS_EN
    if (commit && (src == W_dstM_i)) begin
      val = W_valM_i;
    end else if (commit && (src == W_dstE_i)) begin
      val = W_valE_i;
    end
`endif
    if (src == '0) begin
      val = '0;
    end
    return val;
  endfunction

  // Register array and retire counter update; reset dominates any commit.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      // NOTE: the array is built from flops, not a RAM macro, so every entry can be
      // cleared in one reset cycle; a RAM-style array could not be reset like this.
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= (i == SP_IDX) ? SP_RESET : '0;
      end
      instret_q <= '0;
    end else begin
      // NOTE: state uses non-blocking assignments so every read in this block sees
      // the pre-edge value, matching the hardware register behaviour.
      if (commit) begin
        instret_q <= instret_q + 64'd1;
      end
      if (we_e) begin
        regs_q[W_dstE_i] <= W_valE_i;
      end
      if (we_m) begin
        regs_q[W_dstM_i] <= W_valM_i;
      end
    end
  end

  // Combinational read ports.
  always_comb begin
    // NOTE: both outputs get a value on every path through this block, so no latch
    // is inferred.
    d_rvalA_o = read_port(d_srcA_i);
    d_rvalB_o = read_port(d_srcB_i);
  end

  assign instret_o = instret_q;

endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: self-checking bench for wb_regfile. Table-driven commit/read
// vectors go through an expectation queue; hand-written sequences cover
// same-cycle reads, counter wrap and reset overriding a commit.
module tb_wb_regfile;

  localparam logic [63:0] SP_VAL = 64'h0000_0000_0000_8000;
  localparam logic [63:0] ONES   = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        W_valid_i;
  logic [4:0]  W_dstE_i;
  logic [63:0] W_valE_i;
  logic [4:0]  W_dstM_i;
  logic [63:0] W_valM_i;
  logic [4:0]  d_srcA_i;
  logic [4:0]  d_srcB_i;
  logic [63:0] d_rvalA_o;
  logic [63:0] d_rvalB_o;
  logic [63:0] instret_o;

  wb_regfile #(
    .DATA_W   (64),
    .ADDR_W   (5),
    .SP_IDX   (2),
    .SP_RESET (SP_VAL)
  ) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .W_valid_i (W_valid_i),
    .W_dstE_i  (W_dstE_i),
    .W_valE_i  (W_valE_i),
    .W_dstM_i  (W_dstM_i),
    .W_valM_i  (W_valM_i),
    .d_srcA_i  (d_srcA_i),
    .d_srcB_i  (d_srcB_i),
    .d_rvalA_o (d_rvalA_o),
    .d_rvalB_o (d_rvalB_o),
    .instret_o (instret_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        valid;
    logic [4:0]  dste;
    logic [63:0] vale;
    logic [4:0]  dstm;
    logic [63:0] valm;
    logic [4:0]  srca;
    logic [4:0]  srcb;
    logic [63:0] expa;
    logic [63:0] expb;
    logic [63:0] expir;
  } vec_t;

  typedef struct {
    int          idx;
    logic [63:0] expa;
    logic [63:0] expb;
    logic [63:0] expir;
  } exp_t;

  vec_t vecs [9];
  exp_t sb [$];

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic valid, input logic [4:0] dste, input logic [63:0] vale,
                       input logic [4:0] dstm, input logic [63:0] valm,
                       input logic [4:0] srca, input logic [4:0] srcb);
    W_valid_i = valid;
    W_dstE_i  = dste;
    W_valE_i  = vale;
    W_dstM_i  = dstm;
    W_valM_i  = valm;
    d_srcA_i  = srca;
    d_srcB_i  = srcb;
  endtask

  // Pop one expectation and compare it against the post-edge outputs.
  task automatic sample_post();
    exp_t e;
    @(posedge clk_i);
    #1;
    if (sb.size() == 0) begin
      check("scoreboard_empty", 64'd0, 64'd1);
    end else begin
      e = sb.pop_front();
      check($sformatf("vec%0d_rvalA", e.idx), d_rvalA_o, e.expa);
      check($sformatf("vec%0d_rvalB", e.idx), d_rvalB_o, e.expb);
      check($sformatf("vec%0d_instret", e.idx), instret_o, e.expir);
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [63:0] exp_same;

    //          valid dstE   valE          dstM   valM          srcA   srcB   expA          expB          expIR
    vecs[0] = '{1'b0, 5'd0,  64'h0,        5'd0,  64'h0,        5'd2,  5'd0,  SP_VAL,       64'h0,        64'd0};
    vecs[1] = '{1'b1, 5'd5,  64'hA5A5,     5'd0,  64'h0,        5'd5,  5'd1,  64'hA5A5,     64'h0,        64'd1};
    vecs[2] = '{1'b1, 5'd7,  64'h1,        5'd7,  64'h2,        5'd5,  5'd7,  64'hA5A5,     64'h2,        64'd2};
    vecs[3] = '{1'b1, 5'd0,  64'hFFFF,     5'd0,  64'h0,        5'd0,  5'd7,  64'h0,        64'h2,        64'd3};
    vecs[4] = '{1'b0, 5'd3,  64'hDEAD,     5'd3,  64'hBEEF,     5'd3,  5'd5,  64'h0,        64'hA5A5,     64'd3};
    vecs[5] = '{1'b1, 5'd3,  64'h11,       5'd6,  64'h22,       5'd3,  5'd6,  64'h11,       64'h22,       64'd4};
    vecs[6] = '{1'b1, 5'd0,  64'h99,       5'd0,  64'h98,       5'd6,  5'd6,  64'h22,       64'h22,       64'd5};
    vecs[7] = '{1'b1, 5'd31, ONES,         5'd2,  64'h1234,     5'd31, 5'd2,  ONES,         64'h1234,     64'd6};
    vecs[8] = '{1'b1, 5'd0,  64'h55,       5'd0,  64'h55,       5'd0,  5'd31, 64'h0,        ONES,         64'd7};

    // Reset for one cycle.
    rst_i = 1'b1;
    drive(1'b0, 5'd0, 64'h0, 5'd0, 64'h0, 5'd0, 5'd0);
    @(posedge clk_i);
    #1;
    @(negedge clk_i);
    rst_i = 1'b0;

    // Reset state of every register through both ports.
    for (int i = 0; i < 32; i++) begin
      d_srcA_i = 5'(i);
      d_srcB_i = 5'(31 - i);
      #1;
      check($sformatf("reset_reg%0d_A", i), d_rvalA_o, (i == 2) ? SP_VAL : 64'h0);
      check($sformatf("reset_reg%0d_B", 31 - i), d_rvalB_o, ((31 - i) == 2) ? SP_VAL : 64'h0);
    end
    check("reset_instret", instret_o, 64'd0);

    // Table-driven commits and reads.
    for (int v = 0; v < 9; v++) begin
      @(negedge clk_i);
      drive(vecs[v].valid, vecs[v].dste, vecs[v].vale, vecs[v].dstm, vecs[v].valm,
            vecs[v].srca, vecs[v].srcb);
      sb.push_back('{v, vecs[v].expa, vecs[v].expb, vecs[v].expir});
      sample_post();
    end

    // Same-cycle read of an E-port write to reg 9.
    @(negedge clk_i);
    drive(1'b1, 5'd9, 64'h1234, 5'd0, 64'h0, 5'd9, 5'd10);
`ifdef RF_BYPASS_EN
    exp_same = 64'h1234;
`else
    exp_same = 64'h0;
`endif
    #1;
    check("same_cycle_E_rvalA", d_rvalA_o, exp_same);
    @(posedge clk_i);
    #1;
    check("post_edge_E_rvalA", d_rvalA_o, 64'h1234);

    // Same-cycle read when both ports target reg 10: load value wins.
    @(negedge clk_i);
    drive(1'b1, 5'd10, 64'h1, 5'd10, 64'h2, 5'd9, 5'd10);
`ifdef RF_BYPASS_EN
    exp_same = 64'h2;
`else
    exp_same = 64'h0;
`endif
    #1;
    check("same_cycle_M_rvalB", d_rvalB_o, exp_same);
    @(posedge clk_i);
    #1;
    check("post_edge_M_rvalB", d_rvalB_o, 64'h2);
    check("instret_after_11", instret_o, 64'd9);

    // Counter wrap: deposit all-ones, commit once without a register write.
    @(negedge clk_i);
    drive(1'b1, 5'd0, 64'h7, 5'd0, 64'h7, 5'd0, 5'd0);
    dut.instret_q = ONES;
    #1;
    check("instret_preload", instret_o, ONES);
    @(posedge clk_i);
    #1;
    check("instret_wrap", instret_o, 64'd0);

    // Write reg 4, then assert reset together with another commit to reg 4.
    @(negedge clk_i);
    drive(1'b1, 5'd4, 64'h99, 5'd0, 64'h0, 5'd4, 5'd2);
    @(posedge clk_i);
    #1;
    check("pre_reset_reg4", d_rvalA_o, 64'h99);
    check("pre_reset_instret", instret_o, 64'd1);
    @(negedge clk_i);
    rst_i = 1'b1;
    drive(1'b1, 5'd4, 64'h77, 5'd0, 64'h0, 5'd4, 5'd2);
    @(posedge clk_i);
    #1;
    check("reset_commit_reg4", d_rvalA_o, 64'h0);
    check("reset_commit_sp", d_rvalB_o, SP_VAL);
    check("reset_commit_instret", instret_o, 64'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    drive(1'b0, 5'd0, 64'h0, 5'd0, 64'h0, 5'd0, 5'd0);

    if (sb.size() != 0) begin
      check("scoreboard_leftover", 64'(sb.size()), 64'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
